// File: rtl/soc_adc_pkg.sv
// Shared constants, FSM encoding and width helper for the ADC sequencer.
package soc_adc_pkg;

    localparam int unsigned DW_DEF     = 10;
    localparam int unsigned NCH_DEF    = 4;
    localparam int unsigned TO_CYC_DEF = 1023;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT_RDY,
        ST_START,
        ST_WAIT_DV,
        ST_NEXT
    } adc_state_e;

    // Channel index width, never narrower than one bit.
    function automatic int unsigned chw_of(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/soc_adc_seq_controller_if.sv
// Host control, ADC handshake and result signals of the ADC sequencer.
interface soc_adc_seq_controller_if
    import soc_adc_pkg::*;
#(
    parameter int unsigned DW  = DW_DEF,
    parameter int unsigned NCH = NCH_DEF
) ();
    localparam int unsigned CHW = chw_of(NCH);

    logic           adc_en;
    logic           adc_cont_mode;
    logic [NCH-1:0] adc_ch_mask;
    logic [1:0]     adc_avg_log2;
    logic           adc_err_clr;
    logic           adc_ready;
    logic           adc_dvalid;
    logic [DW-1:0]  adc_data_in;

    logic           adc_start;
    logic [CHW-1:0] adc_ch_sel;
    logic [DW-1:0]  adc_data_out;
    logic [CHW-1:0] adc_ch_out;
    logic           adc_strb_out;
    logic           adc_busy;
    logic           adc_done;
    logic           adc_timeout_err;

    modport master (
        input  adc_en, adc_cont_mode, adc_ch_mask, adc_avg_log2, adc_err_clr,
               adc_ready, adc_dvalid, adc_data_in,
        output adc_start, adc_ch_sel, adc_data_out, adc_ch_out, adc_strb_out,
               adc_busy, adc_done, adc_timeout_err
    );

    modport slave (
        output adc_en, adc_cont_mode, adc_ch_mask, adc_avg_log2, adc_err_clr,
               adc_ready, adc_dvalid, adc_data_in,
        input  adc_start, adc_ch_sel, adc_data_out, adc_ch_out, adc_strb_out,
               adc_busy, adc_done, adc_timeout_err
    );

endinterface

// File: rtl/soc_adc_ch_pick.sv
// Finds the next set mask bit above the current channel (or the lowest set bit
// when first is high); wrap flags that no such bit exists.
module soc_adc_ch_pick
    import soc_adc_pkg::*;
#(
    parameter int unsigned NCH = NCH_DEF,
    parameter int unsigned CHW = chw_of(NCH)
) (
    input  logic [NCH-1:0] mask,
    input  logic [CHW-1:0] cur,
    input  logic           first,
    output logic [CHW-1:0] next,
    output logic           wrap
);

    // Descending scan so the lowest qualifying bit is the one that sticks.
    always_comb begin
        next = '0;
        wrap = 1'b1;
        for (int i = NCH - 1; i >= 0; i--) begin
            if (mask[i] && (first || (i > int'(cur)))) begin
                next = CHW'(i);
                wrap = 1'b0;
            end
        end
    end

endmodule

// File: rtl/soc_adc_seq_controller.sv
// Multi-channel ADC sequencer: walks the channel mask, averages 2^n samples per
// channel, and flags conversions whose data-valid never arrives.
module soc_adc_seq_controller
    import soc_adc_pkg::*;
#(
    parameter int unsigned DW     = DW_DEF,
    parameter int unsigned NCH    = NCH_DEF,
    parameter int unsigned TO_CYC = TO_CYC_DEF
) (
    input  logic                      sys_slow_cbus_clk,
    input  logic                      sys_slow_cbus_rst_n,
    soc_adc_seq_controller_if.master  bus
);

    localparam int unsigned CHW = chw_of(NCH);
    localparam int unsigned AW  = DW + 3;
    localparam int unsigned SW  = 4;
    localparam int unsigned TW  = $clog2(TO_CYC + 1);

    adc_state_e     state_q, state_nxt;
    logic           en_d, dv_d;
    logic [NCH-1:0] mask_q;
    logic [CHW-1:0] ch_q;
    logic [1:0]     avg_q;
    logic [AW-1:0]  acc_q;
    logic [SW-1:0]  cnt_q;
    logic [TW-1:0]  to_q;
    logic           discard_q;
    logic           start_q, strb_q, done_q, busy_q, err_q;
    logic [DW-1:0]  data_q;
    logic [CHW-1:0] chout_q;

    logic           en_rise_c, dv_rise_c, sample_done_c, to_hit_c;
    logic [CHW-1:0] first_ch_c, adv_ch_c;
    logic           first_none_c, adv_wrap_c;
    logic           load_c, relatch_c, advance_c, add_c, tick_c, timeout_c, emit_c, done_c;

    assign en_rise_c     = bus.adc_en & ~en_d;
    assign dv_rise_c     = bus.adc_dvalid & ~dv_d;
    assign sample_done_c = (SW'(cnt_q + SW'(1)) == SW'(SW'(1) << avg_q));
    assign to_hit_c      = (to_q == TW'(TO_CYC - 1));

    soc_adc_ch_pick #(.NCH(NCH), .CHW(CHW)) u_pick_first (
        .mask (bus.adc_ch_mask),
        .cur  (CHW'(0)),
        .first(1'b1),
        .next (first_ch_c),
        .wrap (first_none_c)
    );

    soc_adc_ch_pick #(.NCH(NCH), .CHW(CHW)) u_pick_adv (
        .mask (mask_q),
        .cur  (ch_q),
        .first(1'b0),
        .next (adv_ch_c),
        .wrap (adv_wrap_c)
    );

    always_ff @(posedge sys_slow_cbus_clk) begin
        if (!sys_slow_cbus_rst_n) state_q <= ST_IDLE;
        else                      state_q <= state_nxt;
    end

    always_comb begin
        state_nxt = state_q;
        load_c    = 1'b0;
        relatch_c = 1'b0;
        advance_c = 1'b0;
        add_c     = 1'b0;
        tick_c    = 1'b0;
        timeout_c = 1'b0;
        emit_c    = 1'b0;
        done_c    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (en_rise_c && !first_none_c) begin
                    load_c    = 1'b1;
                    state_nxt = ST_WAIT_RDY;
                end
            end
            ST_WAIT_RDY: if (bus.adc_ready) state_nxt = ST_START;
            ST_START:    state_nxt = ST_WAIT_DV;
            ST_WAIT_DV: begin
                if (dv_rise_c) begin
                    add_c     = 1'b1;
                    state_nxt = sample_done_c ? ST_NEXT : ST_WAIT_RDY;
                end else if (to_hit_c) begin
                    timeout_c = 1'b1;
                    state_nxt = ST_NEXT;
                end else begin
                    tick_c = 1'b1;
                end
            end
            ST_NEXT: begin
                emit_c = !discard_q;
                if (bus.adc_en && !adv_wrap_c) begin
                    advance_c = 1'b1;
                    state_nxt = ST_WAIT_RDY;
                end else if (bus.adc_en && bus.adc_cont_mode && !first_none_c) begin
                    relatch_c = 1'b1;
                    state_nxt = ST_WAIT_RDY;
                end else begin
                    done_c    = 1'b1;
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Datapath and registered outputs.
    always_ff @(posedge sys_slow_cbus_clk) begin
        if (!sys_slow_cbus_rst_n) begin
            en_d      <= 1'b0;
            dv_d      <= 1'b0;
            mask_q    <= '0;
            ch_q      <= '0;
            avg_q     <= '0;
            acc_q     <= '0;
            cnt_q     <= '0;
            to_q      <= '0;
            discard_q <= 1'b0;
            start_q   <= 1'b0;
            strb_q    <= 1'b0;
            done_q    <= 1'b0;
            busy_q    <= 1'b0;
            err_q     <= 1'b0;
            data_q    <= '0;
            chout_q   <= '0;
        end else begin
            en_d    <= bus.adc_en;
            dv_d    <= bus.adc_dvalid;
            start_q <= (state_nxt == ST_START);
            busy_q  <= (state_nxt != ST_IDLE);
            strb_q  <= emit_c;
            done_q  <= done_c;

            if (load_c) avg_q <= bus.adc_avg_log2;
            if (load_c || relatch_c) begin
                mask_q <= bus.adc_ch_mask;
                ch_q   <= first_ch_c;
            end else if (advance_c) begin
                ch_q <= adv_ch_c;
            end

            if (load_c || relatch_c || advance_c) begin
                acc_q <= '0;
                cnt_q <= '0;
            end else if (add_c) begin
                acc_q <= acc_q + AW'(bus.adc_data_in);
                cnt_q <= cnt_q + SW'(1);
            end

            if (state_q == ST_START) to_q <= '0;
            else if (tick_c)         to_q <= to_q + TW'(1);

            if (emit_c) begin
                data_q  <= DW'(acc_q >> avg_q);
                chout_q <= ch_q;
            end

            if (timeout_c)              discard_q <= 1'b1;
            else if (state_q == ST_NEXT) discard_q <= 1'b0;

            // A timeout in the same cycle as a clear keeps the flag set.
            if (timeout_c)            err_q <= 1'b1;
            else if (bus.adc_err_clr) err_q <= 1'b0;
        end
    end

    assign bus.adc_start       = start_q;
    assign bus.adc_ch_sel      = ch_q;
    assign bus.adc_data_out    = data_q;
    assign bus.adc_ch_out      = chout_q;
    assign bus.adc_strb_out    = strb_q;
    assign bus.adc_busy        = busy_q;
    assign bus.adc_done        = done_q;
    assign bus.adc_timeout_err = err_q;

endmodule

// File: doc/soc_adc_seq_controller.md
SOC_ADC_SEQ_CONTROLLER -- requirements
Module: soc_adc_seq_controller

Interface
REQ-001 SHALL have parameter DW, default 10, ADC sample width.
REQ-002 SHALL have parameter NCH, default 4, number of ADC channels (2..8); CHW = max(1, clog2(NCH)).
REQ-003 SHALL have parameter TO_CYC, default 1023, dvalid timeout in clocks.
REQ-004 SHALL use one clock and a synchronous, active-low reset: sys_slow_cbus_clk  input  1  clock; sys_slow_cbus_rst_n  input  1  synchronous active-low reset.
REQ-005 SHALL have the following inputs: adc_en (1, sequence request, level), adc_cont_mode (1, 1 = continuous, 0 = single pass), adc_ch_mask (NCH, enabled channels), adc_avg_log2 (2, samples per result = 2^n), adc_err_clr (1, clears the timeout flag), adc_ready (1), adc_dvalid (1), adc_data_in (DW). All inputs are already synchronous to sys_slow_cbus_clk.
REQ-006 SHALL have the following outputs: adc_start (1, conversion start pulse), adc_ch_sel (CHW, channel under conversion), adc_data_out (DW, result), adc_ch_out (CHW, channel of result), adc_strb_out (1, result valid pulse), adc_busy (1), adc_done (1, end-of-sequence pulse), adc_timeout_err (1, sticky).

Function
REQ-007 SHALL detect the adc_en rising edge as adc_en & ~adc_en_d, and the adc_dvalid rising edge the same way, each using a registered delay.
REQ-008 SHALL implement an FSM with states IDLE, WAIT_RDY, START, WAIT_DV and NEXT.
REQ-009 IDLE: on an adc_en rising edge with adc_ch_mask != 0, SHALL latch the mask, select the lowest set channel, clear the accumulator and sample count, and go to WAIT_RDY. A zero mask SHALL ignore the edge.
REQ-010 WAIT_RDY: when adc_ready = 1, SHALL go to START. START SHALL drive adc_start = 1 for exactly one cycle, clear the timeout counter, and go to WAIT_DV.
REQ-011 WAIT_DV: on a dvalid rising edge, SHALL add adc_data_in to the accumulator (DW+3 bits, no overflow possible) and increment the sample count.
REQ-012 When the count reaches 2^adc_avg_log2, SHALL go to NEXT; otherwise it SHALL return to WAIT_RDY.
REQ-013 In NEXT, SHALL register adc_data_out = accumulator >> adc_avg_log2 (truncating) and adc_ch_out = current channel, and assert adc_strb_out for one cycle. The result therefore appears 2 cycles after the last dvalid edge.
REQ-014 adc_avg_log2 SHALL be sampled at sequence start and held for the whole sequence.
REQ-015 If WAIT_DV lasts TO_CYC cycles without a dvalid edge, SHALL set adc_timeout_err, discard the channel's accumulation (no strobe), and advance as in REQ-016.
REQ-016 NEXT SHALL advance to the next higher set bit of the latched mask, clear the accumulator and count, and go to WAIT_RDY.
REQ-017 After the highest set channel, the following SHALL apply:
- if adc_cont_mode = 1 and adc_en = 1: re-latch adc_ch_mask and wrap to its lowest set channel;
- a re-latched mask of zero ends the sequence;
- otherwise: pulse adc_done for one cycle and return to IDLE.
REQ-018 If adc_en falls mid-sequence, SHALL complete the current channel (including its strobe), then pulse adc_done and return to IDLE.
REQ-019 adc_busy SHALL be 1 in every state except IDLE. adc_ch_sel SHALL hold the current channel while busy.
REQ-020 If adc_err_clr and a timeout occur in the same cycle, set SHALL win.
REQ-021 SHALL ignore dvalid edges outside WAIT_DV.

Reset
REQ-022 While sys_slow_cbus_rst_n = 0 at a clock edge, SHALL force:
- FSM to IDLE;
- adc_start, adc_strb_out, adc_done, adc_busy, adc_timeout_err = 0;
- adc_data_out, adc_ch_out, adc_ch_sel, accumulator, counters and edge-detect registers = 0.
REQ-023 Reset asserted mid-sequence SHALL abort without a strobe or done pulse. After release, a new adc_en rising edge SHALL be required to start.

Structure
REQ-024 The FSM state encoding and the default DW/NCH/TO_CYC constants SHALL live in the shared package soc_adc_pkg.
REQ-025 Next-channel selection (mask, current channel -> next set bit, wrap flag) SHALL be the sub-module soc_adc_ch_pick. All other logic SHALL be in the top level.

Verification
REQ-026 NCH=4, mask=4'b0101, avg=0, single; ADC returns 0x155 (ch0) and 0x2AA (ch2) -> two strobes (ch0/0x155, ch2/0x2AA), then one adc_done and adc_busy = 0.
REQ-027 avg=2, mask=4'b0010, samples 100, 101, 102, 104 -> 4 adc_start pulses, one strobe ch1 data 101 (407>>2).
REQ-028 Continuous, mask=4'b1000; adc_en held for 3 results, then dropped during the 4th conversion -> 4 strobes on ch3, one adc_done, return to IDLE.
REQ-029 mask=4'b0011, ch0 dvalid withheld for 1023 cycles -> adc_timeout_err = 1, no ch0 strobe, ch1 strobe follows; adc_err_clr pulse -> 0; err_clr coincident with a new timeout -> stays 1.
REQ-030 Reset pulled low in WAIT_DV -> all outputs 0 next cycle, no strobe. A rising adc_en with mask=0 -> adc_busy stays 0.
